// File: rtl/tpu_pkg.sv
// Shared types and helpers for the systolic matrix-multiply sequencer.
package tpu_pkg;

  localparam int unsigned SizeDefault  = 4;
  localparam int unsigned DataWDefault = 8;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StDrain,
    StDone
  } seq_state_e;

  // A dimension is usable when it is non-zero and fits the array.
  function automatic logic dim_ok(input logic [7:0] dim, input int unsigned size);
    return (dim != 8'd0) && (32'(dim) <= size);
  endfunction

endpackage

// File: rtl/systolic_skew_feeder.sv
// Produces the diagonally skewed A rows / B columns for the systolic array.
// Outputs are registered, so t and feed_en describe the cycle that follows.
module systolic_skew_feeder
  import tpu_pkg::*;
#(
  parameter int unsigned SIZE   = SizeDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     feed_en,
  input  logic [7:0]                               t,
  input  logic [7:0]                               dim_m,
  input  logic [7:0]                               dim_k,
  input  logic [7:0]                               dim_n,
  input  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0]    a_mat,
  input  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0]    b_mat,
  output logic [SIZE-1:0][DATA_W-1:0]              arr_left,
  output logic [SIZE-1:0][DATA_W-1:0]              arr_top
);

  logic [SIZE-1:0][DATA_W-1:0] left_d, left_q;
  logic [SIZE-1:0][DATA_W-1:0] top_d, top_q;

  // Row i carries a[i][k] at t = i + k; column j carries b[k][j] at t = j + k.
  always_comb begin
    left_d = '0;
    top_d  = '0;
    if (feed_en) begin
      for (int i = 0; i < SIZE; i++) begin
        for (int k = 0; k < SIZE; k++) begin
          if ((8'(k) < dim_k) && (t == 8'(i + k))) begin
            if (8'(i) < dim_m) left_d[i] = a_mat[i][k];
            if (8'(i) < dim_n) top_d[i]  = b_mat[k][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_q <= '0;
      top_q  <= '0;
    end else begin
      left_q <= left_d;
      top_q  <= top_d;
    end
  end

  assign arr_left = left_q;
  assign arr_top  = top_q;

endmodule

// File: rtl/systolic_sequencer.sv
// Runs one C = A * B job on the SIZE x SIZE systolic array: clear, skewed feed,
// bottom-up drain into row strobes, then a done pulse.
module systolic_sequencer
  import tpu_pkg::*;
#(
  parameter int unsigned SIZE   = SizeDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  start,
  input  logic [7:0]                            dim_m,
  input  logic [7:0]                            dim_k,
  input  logic [7:0]                            dim_n,
  input  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] a_mat,
  input  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] b_mat,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err,
  output logic                                  arr_reset,
  output logic                                  arr_through,
  output logic [SIZE-1:0][DATA_W-1:0]           arr_left,
  output logic [SIZE-1:0][DATA_W-1:0]           arr_top,
  input  logic [SIZE-1:0][DATA_W-1:0]           arr_down,
  output logic                                  c_wr_en,
  output logic [7:0]                            c_wr_row,
  output logic [SIZE-1:0][DATA_W-1:0]           c_wr_data
);

  seq_state_e                           state_q;
  logic [7:0]                           cnt_q;
  logic [7:0]                           m_q, k_q, n_q;
  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] a_q, b_q;

  logic                                 busy_q, done_q, err_q;
  logic                                 arr_reset_q, arr_through_q;
  logic                                 c_wr_en_q;
  logic [7:0]                           c_wr_row_q;
  logic [SIZE-1:0][DATA_W-1:0]          c_wr_data_q;

  logic                                 dims_ok;
  logic [7:0]                           feed_last;
  logic [7:0]                           drain_row;
  logic [SIZE-1:0][DATA_W-1:0]          down_masked;
  logic                                 feed_en;
  logic [7:0]                           feed_t;

  assign dims_ok   = dim_ok(dim_m, SIZE) && dim_ok(dim_k, SIZE) && dim_ok(dim_n, SIZE);
  // Feed lasts K + 2*SIZE - 2 cycles so the far corner PE sees its last operand pair.
  assign feed_last = k_q + 8'(2 * SIZE - 3);
  assign drain_row = 8'(SIZE - 1) - cnt_q;

  always_comb begin
    down_masked = '0;
    for (int j = 0; j < SIZE; j++) begin
      if (8'(j) < n_q) down_masked[j] = arr_down[j];
    end
  end

  // Feeder registers its outputs, so hand it the index for the coming cycle.
  assign feed_en = (state_q == StClear) || ((state_q == StFeed) && (cnt_q != feed_last));
  assign feed_t  = (state_q == StClear) ? 8'd0 : cnt_q + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      m_q           <= '0;
      k_q           <= '0;
      n_q           <= '0;
      a_q           <= '0;
      b_q           <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      arr_reset_q   <= 1'b1;
      arr_through_q <= 1'b0;
      c_wr_en_q     <= 1'b0;
      c_wr_row_q    <= '0;
      c_wr_data_q   <= '0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      c_wr_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          arr_reset_q <= 1'b0;
          if (start) begin
            if (dims_ok) begin
              a_q         <= a_mat;
              b_q         <= b_mat;
              m_q         <= dim_m;
              k_q         <= dim_k;
              n_q         <= dim_n;
              busy_q      <= 1'b1;
              arr_reset_q <= 1'b1;
              state_q     <= StClear;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StClear: begin
          arr_reset_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= StFeed;
        end
        StFeed: begin
          if (cnt_q == feed_last) begin
            cnt_q         <= '0;
            arr_through_q <= 1'b1;
            state_q       <= StDrain;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDrain: begin
          if (drain_row < m_q) begin
            c_wr_en_q   <= 1'b1;
            c_wr_row_q  <= drain_row;
            c_wr_data_q <= down_masked;
          end
          if (cnt_q == 8'(SIZE - 1)) begin
            cnt_q         <= '0;
            arr_through_q <= 1'b0;
            done_q        <= 1'b1;
            state_q       <= StDone;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  systolic_skew_feeder #(
    .SIZE   (SIZE),
    .DATA_W (DATA_W)
  ) u_feeder (
    .clk      (clk),
    .reset_n  (reset_n),
    .feed_en  (feed_en),
    .t        (feed_t),
    .dim_m    (m_q),
    .dim_k    (k_q),
    .dim_n    (n_q),
    .a_mat    (a_q),
    .b_mat    (b_q),
    .arr_left (arr_left),
    .arr_top  (arr_top)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign arr_reset   = arr_reset_q;
  assign arr_through = arr_through_q;
  assign c_wr_en     = c_wr_en_q;
  assign c_wr_row    = c_wr_row_q;
  assign c_wr_data   = c_wr_data_q;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer with a behavioural output-stationary array.
module tb_systolic_sequencer;

  localparam int unsigned SIZE   = 4;
  localparam int unsigned DATA_W = 8;

  typedef logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] mat_t;
  typedef logic [SIZE-1:0][DATA_W-1:0]           row_t;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] dim_m, dim_k, dim_n;
  mat_t       a_mat, b_mat;
  logic       busy, done, err, arr_reset, arr_through;
  row_t       arr_left, arr_top, arr_down;
  logic       c_wr_en;
  logic [7:0] c_wr_row;
  row_t       c_wr_data;

  systolic_sequencer #(
    .SIZE   (SIZE),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dim_m       (dim_m),
    .dim_k       (dim_k),
    .dim_n       (dim_n),
    .a_mat       (a_mat),
    .b_mat       (b_mat),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .arr_reset   (arr_reset),
    .arr_through (arr_through),
    .arr_left    (arr_left),
    .arr_top     (arr_top),
    .arr_down    (arr_down),
    .c_wr_en     (c_wr_en),
    .c_wr_row    (c_wr_row),
    .c_wr_data   (c_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: A flows right, B flows down, each PE accumulates; drain shifts rows down.
  mat_t pe_a, pe_b, acc, a_in, b_in;
  localparam logic [SIZE*DATA_W-1:0] RowZero = '0;

  always_comb begin
    a_in = '0;
    for (int i = 0; i < SIZE; i++) a_in[i] = {pe_a[i][SIZE-2:0], arr_left[i]};
    b_in = {pe_b[SIZE-2:0], arr_top};
  end

  always_ff @(posedge clk) begin
    if (arr_reset) begin
      pe_a <= '0;
      pe_b <= '0;
      acc  <= '0;
    end else if (arr_through) begin
      acc <= {acc[SIZE-2:0], RowZero};
    end else begin
      pe_a <= a_in;
      pe_b <= b_in;
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++)
          acc[i][j] <= acc[i][j] + a_in[i][j] * b_in[i][j];
    end
  end

  assign arr_down = acc[SIZE-1];

  int n_checks = 0;
  int n_fail   = 0;

  int          busy_first, busy_last, done_cyc, done_cnt, n_str;
  int          str_row [8];
  logic [31:0] str_data[8];
  int          str_cyc [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [7:0] m, input logic [7:0] k, input logic [7:0] n,
                        input mat_t a, input mat_t b);
    @(negedge clk);
    dim_m = m; dim_k = k; dim_n = n; a_mat = a; b_mat = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Samples mid-cycle; cycle numbers count from the accept cycle (0).
  task automatic collect(input int first);
    busy_first = -1; busy_last = -1; done_cyc = -1; done_cnt = 0; n_str = 0;
    for (int c = first; c < first + 60; c++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c_wr_en === 1'b1 && n_str < 8) begin
        str_row[n_str]  = int'(c_wr_row);
        str_data[n_str] = c_wr_data;
        str_cyc[n_str]  = c;
        n_str++;
      end
      if (busy_first >= 0 && busy !== 1'b1) break;
    end
  endtask

  mat_t a1, b1, a_id, b_seq, a_ov, b_ov;

  initial begin
    a1 = '0; a1[0][0] = 1; a1[0][1] = 2; a1[0][2] = 3; a1[1][0] = 4; a1[1][1] = 5; a1[1][2] = 6;
    b1 = '0; b1[0][0] = 7; b1[1][0] = 8; b1[2][0] = 9;
    a_id = '0; b_seq = '0;
    for (int r = 0; r < SIZE; r++) begin
      a_id[r][r] = 8'd1;
      for (int c = 0; c < SIZE; c++) b_seq[r][c] = 8'(4 * r + c);
    end
    a_ov = '0; a_ov[0][0] = 8'd16;
    b_ov = '0; b_ov[0][0] = 8'd16;

    reset_n = 1'b0; start = 1'b0;
    dim_m = '0; dim_k = '0; dim_n = '0; a_mat = '0; b_mat = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_arr_reset", 32'(arr_reset), 32'd1);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_through_wr", {30'd0, arr_through, c_wr_en}, 32'd0);
    check("rst_left_top", arr_left | arr_top, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_arr_reset", 32'(arr_reset), 32'd0);

    // Job 1: 2x3 * 3x1
    launch(8'd2, 8'd3, 8'd1, a1, b1);
    collect(1);
    check("j1_busy_first", busy_first, 32'd1);
    check("j1_busy_last", busy_last, 32'd15);
    check("j1_done_cyc", done_cyc, 32'd15);
    check("j1_done_cnt", done_cnt, 32'd1);
    check("j1_n_str", n_str, 32'd2);
    check("j1_row_a", str_row[0], 32'd1);
    check("j1_data_a", str_data[0], 32'd122);
    check("j1_cyc_a", str_cyc[0], 32'd14);
    check("j1_row_b", str_row[1], 32'd0);
    check("j1_data_b", str_data[1], 32'd50);
    check("j1_cyc_b", str_cyc[1], 32'd15);

    // Job 2: identity times sequential B
    launch(8'd4, 8'd4, 8'd4, a_id, b_seq);
    collect(1);
    check("j2_done_cyc", done_cyc, 32'd16);
    check("j2_n_str", n_str, 32'd4);
    check("j2_row0", str_row[0], 32'd3);
    check("j2_data0", str_data[0], 32'h0f0e0d0c);
    check("j2_row1", str_row[1], 32'd2);
    check("j2_data1", str_data[1], 32'h0b0a0908);
    check("j2_row2", str_row[2], 32'd1);
    check("j2_data2", str_data[2], 32'h07060504);
    check("j2_row3", str_row[3], 32'd0);
    check("j2_data3", str_data[3], 32'h03020100);
    check("j2_cyc3", str_cyc[3], 32'd16);

    // Bad dimensions
    launch(8'd4, 8'd0, 8'd4, a_id, b_seq);
    @(negedge clk);
    check("err_k0_pulse", 32'(err), 32'd1);
    check("err_k0_busy", 32'(busy), 32'd0);
    check("err_k0_arr_reset", 32'(arr_reset), 32'd0);
    @(negedge clk);
    check("err_k0_clear", 32'(err), 32'd0);
    launch(8'd4, 8'd4, 8'd5, a_id, b_seq);
    @(negedge clk);
    check("err_n5_pulse", 32'(err), 32'd1);
    check("err_n5_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("err_n5_clear", 32'(err), 32'd0);
    check("err_n5_busy2", 32'(busy), 32'd0);

    // start held across the whole job and DONE
    @(negedge clk);
    dim_m = 8'd2; dim_k = 8'd3; dim_n = 8'd1; a_mat = a1; b_mat = b1;
    start = 1'b1;
    done_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("hold_one_done", done_cnt, 32'd1);
    check("hold_idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    check("hold_reaccept", 32'(busy), 32'd1);
    start = 1'b0;
    collect(2);
    check("hold_j2_done_cyc", done_cyc, 32'd15);
    check("hold_j2_n_str", n_str, 32'd2);
    check("hold_j2_data_a", str_data[0], 32'd122);
    check("hold_j2_data_b", str_data[1], 32'd50);

    // Reset during FEED
    launch(8'd4, 8'd4, 8'd4, a_id, b_seq);
    repeat (4) @(negedge clk);
    check("feed_left_t2", arr_left, 32'h00000100);
    @(negedge clk);
    check("feed_top_t3", arr_top, 32'h0306090c);
    reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_arr_reset", 32'(arr_reset), 32'd1);
    check("abort_left_top", arr_left | arr_top, 32'd0);
    check("abort_misc", {29'd0, done, arr_through, c_wr_en}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    launch(8'd2, 8'd3, 8'd1, a1, b1);
    collect(1);
    check("rerun_done_cyc", done_cyc, 32'd15);
    check("rerun_n_str", n_str, 32'd2);
    check("rerun_data_a", str_data[0], 32'd122);
    check("rerun_data_b", str_data[1], 32'd50);

    // Overflow wraps mod 256
    launch(8'd1, 8'd1, 8'd1, a_ov, b_ov);
    collect(1);
    check("ovf_done_cyc", done_cyc, 32'd13);
    check("ovf_n_str", n_str, 32'd1);
    check("ovf_row", str_row[0], 32'd0);
    check("ovf_data", str_data[0], 32'd0);
    check("ovf_cyc", str_cyc[0], 32'd13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
